// File: rtl/ivmul_pipe_if.sv
// ivmul_pipe_if: op/result handshake bundle for the packed-SIMD multiplier
interface ivmul_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAG_W = 6
);
    logic flush_i;
    logic valid_i;
    logic ready_o;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [2:0] opc_i;
    logic [TAG_W-1:0] tag_i;
    logic valid_o;
    logic ready_i;
    logic [XLEN-1:0] result_o;
    logic [TAG_W-1:0] tag_o;
    modport master (
        output flush_i, valid_i, a_i, b_i, opc_i, tag_i, ready_i,
        input ready_o, valid_o, result_o, tag_o
    );
    modport slave (
        input flush_i, valid_i, a_i, b_i, opc_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o
    );
endinterface

// File: rtl/ivmul_pipe.sv
// ivmul_pipe: two-stage packed-SIMD multiplier with lane products, dot product and accumulator
module ivmul_pipe #(
    parameter int XLEN = 32,
    parameter int LANE_W = 16,
    parameter int TAG_W = 6
) (
    input logic cpu_clock_i,
    input logic cpu_reset_i,
    ivmul_pipe_if.slave io
);
    localparam int LANES = XLEN / LANE_W;
    localparam int PW = 2 * LANE_W;
    localparam logic [2:0] OP_MULL = 3'd0;
    localparam logic [2:0] OP_MULH = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DOT = 3'd3;
    localparam logic [2:0] OP_MACC = 3'd4;
    localparam logic [2:0] OP_ACCRD = 3'd5;

    logic [PW-1:0] prod_d [LANES];
    logic [PW-1:0] s1_prod [LANES];
    logic [2:0] s1_opc;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic s1_valid;
    logic s2_valid;
    logic [XLEN-1:0] s2_result;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] dot;
    logic [XLEN-1:0] res;
    logic sgn;
    logic s1_adv;
    logic s2_adv;
    logic xfer;

    assign s2_adv = !s2_valid || io.ready_i;
    assign s1_adv = !s1_valid || s2_adv;
    assign io.ready_o = s1_adv && !io.flush_i;
    assign xfer = s1_valid && s2_adv;
    assign sgn = io.opc_i != OP_MULHU;

    // One extra operand bit lets a single signed multiplier serve both signed and unsigned lanes
    always_comb begin
        for (int k = 0; k < LANES; k++)
            prod_d[k] = PW'($signed({sgn & io.a_i[k*LANE_W+LANE_W-1], io.a_i[k*LANE_W +: LANE_W]}))
                      * PW'($signed({sgn & io.b_i[k*LANE_W+LANE_W-1], io.b_i[k*LANE_W +: LANE_W]}));
    end

    always_comb begin
        lo = '0;
        hi = '0;
        dot = '0;
        for (int k = 0; k < LANES; k++) begin
            lo[k*LANE_W +: LANE_W] = s1_prod[k][LANE_W-1:0];
            hi[k*LANE_W +: LANE_W] = s1_prod[k][PW-1:LANE_W];
            dot = dot + XLEN'($signed(s1_prod[k]));
        end
    end

    assign res = s1_opc == OP_MULL ? lo :
                 (s1_opc == OP_MULH || s1_opc == OP_MULHU) ? hi :
                 s1_opc == OP_DOT ? dot :
                 s1_opc == OP_MACC ? acc + dot :
                 s1_opc == OP_ACCRD ? acc : '0;

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_opc <= '0;
            s1_tag <= '0;
            s2_tag <= '0;
            s2_result <= '0;
            acc <= '0;
            for (int k = 0; k < LANES; k++) s1_prod[k] <= '0;
        end else if (io.flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= io.valid_i;
                if (io.valid_i) begin
                    s1_opc <= io.opc_i;
                    s1_tag <= io.tag_i;
                    s1_prod <= prod_d;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= res;
                    s2_tag <= s1_tag;
                end
            end
            // Accumulator commits only as its op leaves S1, so a flushed op never touches it
            if (xfer && s1_opc == OP_MACC) acc <= res;
            else if (xfer && s1_opc == OP_ACCRD) acc <= '0;
        end
    end

    assign io.valid_o = s2_valid;
    assign io.result_o = s2_result;
    assign io.tag_o = s2_tag;
endmodule

// File: tb/tb_ivmul_pipe.sv
// tb_ivmul_pipe: directed checks of ivmul_pipe with 16-bit and 8-bit lane instances
module tb_ivmul_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    localparam logic [31:0] A1 = 32'hFFFF0002;
    localparam logic [31:0] B1 = 32'h00030004;

    always #5 clk = ~clk;

    ivmul_pipe_if #(.XLEN(32), .TAG_W(6)) bus16 ();
    ivmul_pipe_if #(.XLEN(32), .TAG_W(6)) bus8 ();

    ivmul_pipe #(.XLEN(32), .LANE_W(16), .TAG_W(6)) dut16 (
        .cpu_clock_i(clk),
        .cpu_reset_i(rst),
        .io(bus16)
    );

    ivmul_pipe #(.XLEN(32), .LANE_W(8), .TAG_W(6)) dut8 (
        .cpu_clock_i(clk),
        .cpu_reset_i(rst),
        .io(bus8)
    );

    task automatic drive16(input logic v, input logic [2:0] opc, input logic [5:0] tag,
                           input logic [31:0] a, input logic [31:0] b);
        bus16.valid_i = v;
        bus16.opc_i = opc;
        bus16.tag_i = tag;
        bus16.a_i = a;
        bus16.b_i = b;
    endtask

    task automatic drive8(input logic v, input logic [2:0] opc, input logic [5:0] tag,
                          input logic [31:0] a, input logic [31:0] b);
        bus8.valid_i = v;
        bus8.opc_i = opc;
        bus8.tag_i = tag;
        bus8.a_i = a;
        bus8.b_i = b;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
        drive8(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
        bus16.flush_i = 1'b0;
        bus16.ready_i = 1'b1;
        bus8.flush_i = 1'b0;
        bus8.ready_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== 39'h0) begin
            failures++;
            $display("FAIL reset16_outputs got=%h exp=0", {bus16.valid_o, bus16.result_o, bus16.tag_o});
        end
        checks++;
        if (dut16.acc !== 32'h0) begin
            failures++;
            $display("FAIL reset16_acc got=%h exp=0", dut16.acc);
        end
        checks++;
        if (bus16.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset16_ready got=%b exp=1", bus16.ready_o);
        end
        checks++;
        if ({bus8.valid_o, bus8.result_o, bus8.tag_o} !== 39'h0) begin
            failures++;
            $display("FAIL reset8_outputs got=%h exp=0", {bus8.valid_o, bus8.result_o, bus8.tag_o});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lanes16;
        logic [2:0] opcs [4];
        logic [31:0] exps [4];
        opcs = '{3'd0, 3'd1, 3'd2, 3'd3};
        exps = '{32'hFFFD0008, 32'hFFFF0000, 32'h00020000, 32'h00000005};
        for (int i = 0; i < 4; i++) begin
            drive16(1'b1, opcs[i], 6'(10 + i), A1, B1);
            @(negedge clk);
            drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
            checks++;
            if (bus16.valid_o !== 1'b0) begin
                failures++;
                $display("FAIL lanes16_early op=%0d got=%b exp=0", i, bus16.valid_o);
            end
            @(negedge clk);
            checks++;
            if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== {1'b1, exps[i], 6'(10 + i)}) begin
                failures++;
                $display("FAIL lanes16 op=%0d got=%h exp=%h", i,
                         {bus16.valid_o, bus16.result_o, bus16.tag_o}, {1'b1, exps[i], 6'(10 + i)});
            end
        end
    endtask

    task automatic test_lanes8;
        logic [2:0] opcs [3];
        logic [31:0] exps [3];
        opcs = '{3'd0, 3'd1, 3'd3};
        exps = '{32'h00000000, 32'h40404040, 32'h00010000};
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, opcs[i], 6'(40 + i), 32'h80808080, 32'h80808080);
            @(negedge clk);
            drive8(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
            @(negedge clk);
            checks++;
            if ({bus8.valid_o, bus8.result_o, bus8.tag_o} !== {1'b1, exps[i], 6'(40 + i)}) begin
                failures++;
                $display("FAIL lanes8 op=%0d got=%h exp=%h", i,
                         {bus8.valid_o, bus8.result_o, bus8.tag_o}, {1'b1, exps[i], 6'(40 + i)});
            end
        end
    endtask

    task automatic test_back_to_back_accum;
        logic [2:0] opcs [4];
        logic [31:0] exps [4];
        opcs = '{3'd4, 3'd4, 3'd5, 3'd5};
        exps = '{32'h5, 32'hA, 32'hA, 32'h0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                checks++;
                if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== {1'b1, exps[i-2], 6'(20 + i - 2)}) begin
                    failures++;
                    $display("FAIL accum op=%0d got=%h exp=%h", i - 2,
                             {bus16.valid_o, bus16.result_o, bus16.tag_o}, {1'b1, exps[i-2], 6'(20 + i - 2)});
                end
            end
            if (i < 4) drive16(1'b1, opcs[i], 6'(20 + i), A1, B1);
            else drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int rx = 0;
        logic held = 1'b0;
        logic dropped = 1'b0;
        logic [31:0] hv = '0;
        logic [5:0] ht = '0;
        logic [37:0] want;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            bus16.ready_i = !(c >= 3 && c <= 6);
            if (sent < 6) drive16(1'b1, 3'd0, 6'(30 + sent), {16'd2, 16'(sent + 1)}, {16'd5, 16'd3});
            else drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
            #1;
            if (bus16.valid_o) begin
                if (held) begin
                    checks++;
                    if ({bus16.result_o, bus16.tag_o} !== {hv, ht}) begin
                        failures++;
                        $display("FAIL bp_stable cycle=%0d got=%h exp=%h", c, {bus16.result_o, bus16.tag_o}, {hv, ht});
                    end
                end
                if (bus16.ready_i) begin
                    want = {32'h000A0000 | 32'(3 * (rx + 1)), 6'(30 + rx)};
                    checks++;
                    if ({bus16.result_o, bus16.tag_o} !== want) begin
                        failures++;
                        $display("FAIL bp_order idx=%0d got=%h exp=%h", rx, {bus16.result_o, bus16.tag_o}, want);
                    end
                    rx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hv = bus16.result_o;
                    ht = bus16.tag_o;
                end
            end
            if (!bus16.ready_o) dropped = 1'b1;
            if (bus16.valid_i && bus16.ready_o) sent++;
            @(negedge clk);
        end
        bus16.ready_i = 1'b1;
        drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
        checks++;
        if (rx != 6) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=6", rx);
        end
        checks++;
        if (dropped !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_drop got=%b exp=1", dropped);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        do_reset();
        drive16(1'b1, 3'd4, 6'd1, A1, B1);
        @(negedge clk);
        drive16(1'b1, 3'd4, 6'd2, A1, B1);
        @(negedge clk);
        checks++;
        if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== {1'b1, 32'h5, 6'd1}) begin
            failures++;
            $display("FAIL flush_first got=%h exp=%h", {bus16.valid_o, bus16.result_o, bus16.tag_o}, {1'b1, 32'h5, 6'd1});
        end
        drive16(1'b1, 3'd4, 6'd9, A1, B1);
        bus16.flush_i = 1'b1;
        #1;
        checks++;
        if (bus16.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", bus16.ready_o);
        end
        @(negedge clk);
        bus16.flush_i = 1'b0;
        checks++;
        if (bus16.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill got=%b exp=0", bus16.valid_o);
        end
        drive16(1'b1, 3'd5, 6'd3, A1, B1);
        @(negedge clk);
        drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
        checks++;
        if (bus16.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_gap got=%b exp=0", bus16.valid_o);
        end
        @(negedge clk);
        checks++;
        if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== {1'b1, 32'h5, 6'd3}) begin
            failures++;
            $display("FAIL flush_accrd got=%h exp=%h", {bus16.valid_o, bus16.result_o, bus16.tag_o}, {1'b1, 32'h5, 6'd3});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        do_reset();
        drive16(1'b1, 3'd4, 6'd1, A1, B1);
        @(negedge clk);
        drive16(1'b1, 3'd0, 6'd2, A1, B1);
        @(negedge clk);
        drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
        checks++;
        if ({bus16.valid_o, bus16.result_o} !== {1'b1, 32'h5}) begin
            failures++;
            $display("FAIL areset_pre got=%h exp=%h", {bus16.valid_o, bus16.result_o}, {1'b1, 32'h5});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== 39'h0) begin
            failures++;
            $display("FAIL areset_outputs got=%h exp=0", {bus16.valid_o, bus16.result_o, bus16.tag_o});
        end
        checks++;
        if (dut16.acc !== 32'h0) begin
            failures++;
            $display("FAIL areset_acc got=%h exp=0", dut16.acc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus16.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL areset_drain got=%b exp=0", bus16.valid_o);
        end
    endtask

    task automatic test_illegal_opc;
        logic [2:0] opcs [3];
        logic [31:0] exps [3];
        opcs = '{3'd4, 3'd7, 3'd5};
        exps = '{32'h5, 32'h0, 32'h5};
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                checks++;
                if ({bus16.valid_o, bus16.result_o, bus16.tag_o} !== {1'b1, exps[i-2], 6'(50 + i - 2)}) begin
                    failures++;
                    $display("FAIL illegal op=%0d got=%h exp=%h", i - 2,
                             {bus16.valid_o, bus16.result_o, bus16.tag_o}, {1'b1, exps[i-2], 6'(50 + i - 2)});
                end
            end
            if (i < 3) drive16(1'b1, opcs[i], 6'(50 + i), A1, B1);
            else drive16(1'b0, 3'd0, 6'd0, 32'd0, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lanes16();
        test_lanes8();
        test_back_to_back_accum();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_illegal_opc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
